// File: rtl/data_mem_controller.sv
// data_mem_controller
// MEM-stage data memory controller. Turns the MEM-stage load/store (including
// LL/SC) into a req/ack data-bus transaction with big-endian byte lanes. It
// holds M_Stall_Controller high until the access completes, then returns the
// aligned and extended load data, or the SC status word.
// Optional feature: define DMEM_TIMEOUT_EN to abort an access that gets no
// Ack within TIMEOUT_CYCLES bus cycles. The abort raises a one-cycle BusError
// pulse. Without the macro, ACCESS waits indefinitely and BusError is tied 0.
module data_mem_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        LLSC,
    input  logic [1:0]  Size,
    input  logic        SignExtend,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        Pipe_Stall,
    input  logic        Eret,
    output logic [31:0] ReadData,
    output logic        M_Stall_Controller,
    output logic        AddrError,
    output logic        BusError,
    output logic [29:0] DataMem_Addr,
    output logic [31:0] DataMem_WriteData,
    output logic [3:0]  DataMem_ByteEn,
    output logic        DataMem_Read,
    output logic        DataMem_Write,
    input  logic        DataMem_Ack,
    input  logic [31:0] DataMem_ReadData
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        aligned;
    logic        req;
    logic        is_sc;
    logic        sc_fail;
    logic        ack_in_access;
    logic        timeout_hit;
    logic [3:0]  byte_en_c;
    logic [31:0] wdata_c;

    logic        ll_valid;
    logic [29:0] ll_addr;

    // Context of the access in flight, captured when the bus request is issued.
    logic        op_load;
    logic        op_ll;
    logic        op_sc;
    logic        op_sext;
    logic [1:0]  op_size;
    logic [1:0]  op_off;

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;

    // Decode the request: alignment, big-endian byte lanes and replicated store data.
    always_comb begin
        // NOTE: each output of this block gets a default before the case statement.
        // A path that leaves one unassigned would infer a latch.
        aligned   = 1'b1;
        byte_en_c = 4'b1111;
        wdata_c   = WriteData;
        case (Size)
            2'b00: begin
                byte_en_c = 4'b1000 >> Address[1:0];
                wdata_c   = {4{WriteData[7:0]}};
            end
            2'b01: begin
                aligned   = ~Address[0];
                byte_en_c = Address[1] ? 4'b0011 : 4'b1100;
                wdata_c   = {2{WriteData[15:0]}};
            end
            default: begin
                aligned   = (Address[1:0] == 2'b00);
            end
        endcase
    end

    assign req           = (MemRead | MemWrite) & aligned;
    assign AddrError     = (MemRead | MemWrite) & ~aligned;
    assign is_sc         = MemWrite & LLSC;
    assign sc_fail       = ~ll_valid | (Address[31:2] != ll_addr);
    assign ack_in_access = (state_q == S_ACCESS) & DataMem_Ack;

    // Select the addressed lane of the returned word, then zero- or sign-extend it.
    always_comb begin
        lane_byte = DataMem_ReadData[{~op_off, 3'b000} +: 8];
        lane_half = op_off[1] ? DataMem_ReadData[15:0] : DataMem_ReadData[31:16];
        load_data = DataMem_ReadData;
        case (op_size)
            2'b00:   load_data = {{24{op_sext & lane_byte[7]}}, lane_byte};
            2'b01:   load_data = {{16{op_sext & lane_half[15]}}, lane_half};
            default: load_data = DataMem_ReadData;
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned TIMER_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                      $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TIMER_W-1:0] timer_q;
    logic               bus_error_q;

    // The abort fires in the last strobe cycle of the TIMEOUT_CYCLES window.
    assign timeout_hit = (state_q == S_ACCESS) & ~DataMem_Ack &
                         (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    // Count the strobe cycles of the current access. The count restarts outside ACCESS.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
        end else if (state_q == S_ACCESS) begin
            timer_q <= timer_q + TIMER_W'(1);
        end else begin
            timer_q <= '0;
        end
    end

    // Drive the one-cycle abort flag, which shows in the first DONE cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus_error_q <= 1'b0;
        end else begin
            bus_error_q <= timeout_hit;
        end
    end

    assign BusError = bus_error_q;
`else
    assign timeout_hit = 1'b0;
    assign BusError    = 1'b0;
`endif

    // Hold the FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before the edge.
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Compute the next state and the stall request. The stall is high from the request cycle until DONE.
    always_comb begin
        state_d            = state_q;
        M_Stall_Controller = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    M_Stall_Controller = 1'b1;
                    state_d            = (is_sc && sc_fail) ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                M_Stall_Controller = 1'b1;
                if (DataMem_Ack || timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!Pipe_Stall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Register the bus request, keep the access context, and capture the result on Ack.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: the datapath registers are reset too. Out of reset the bus
        // address, byte enables and ReadData read 0 rather than X.
        if (!reset_n) begin
            DataMem_Read      <= 1'b0;
            DataMem_Write     <= 1'b0;
            DataMem_Addr      <= '0;
            DataMem_ByteEn    <= '0;
            DataMem_WriteData <= '0;
            ReadData          <= '0;
            op_load           <= 1'b0;
            op_ll             <= 1'b0;
            op_sc             <= 1'b0;
            op_sext           <= 1'b0;
            op_size           <= '0;
            op_off            <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        if (is_sc && sc_fail) begin
                            ReadData <= '0;
                        end else begin
                            DataMem_Read      <= ~MemWrite;
                            DataMem_Write     <= MemWrite;
                            DataMem_Addr      <= Address[31:2];
                            DataMem_ByteEn    <= byte_en_c;
                            DataMem_WriteData <= wdata_c;
                            op_load           <= ~MemWrite;
                            op_ll             <= ~MemWrite & LLSC;
                            op_sc             <= is_sc;
                            op_sext           <= SignExtend;
                            op_size           <= Size;
                            op_off            <= Address[1:0];
                        end
                    end
                end
                S_ACCESS: begin
                    if (DataMem_Ack) begin
                        DataMem_Read  <= 1'b0;
                        DataMem_Write <= 1'b0;
                        if (op_load) begin
                            ReadData <= load_data;
                        end else if (op_sc) begin
                            ReadData <= 32'd1;
                        end
                    end else if (timeout_hit) begin
                        DataMem_Read  <= 1'b0;
                        DataMem_Write <= 1'b0;
                        ReadData      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Maintain the LL reservation. An acknowledged LL sets it. Eret clears it,
    // and Eret wins over a coinciding LL Ack. A completed store to the reserved
    // word also clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ll_valid <= 1'b0;
            ll_addr  <= '0;
        end else if (Eret) begin
            ll_valid <= 1'b0;
        end else if (ack_in_access) begin
            if (op_ll) begin
                ll_valid <= 1'b1;
                ll_addr  <= DataMem_Addr;
            end else if (DataMem_Write && (DataMem_Addr == ll_addr)) begin
                ll_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_controller.sv
// tb_data_mem_controller
// Directed bench for data_mem_controller. A transaction-level model derives
// byte lanes, replicated store data, extracted load data, SC outcome and the
// LL reservation from plain arithmetic. A per-cycle compare process checks the
// DUT against that model. Literal checks after each case pin the model itself.
module tb_data_mem_controller;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        MemRead;
    logic        MemWrite;
    logic        LLSC;
    logic [1:0]  Size;
    logic        SignExtend;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        Pipe_Stall;
    logic        Eret;
    logic [31:0] ReadData;
    logic        M_Stall_Controller;
    logic        AddrError;
    logic        BusError;
    logic [29:0] DataMem_Addr;
    logic [31:0] DataMem_WriteData;
    logic [3:0]  DataMem_ByteEn;
    logic        DataMem_Read;
    logic        DataMem_Write;
    logic        DataMem_Ack;
    logic [31:0] DataMem_ReadData;

    data_mem_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .MemRead            (MemRead),
        .MemWrite           (MemWrite),
        .LLSC               (LLSC),
        .Size               (Size),
        .SignExtend         (SignExtend),
        .Address            (Address),
        .WriteData          (WriteData),
        .Pipe_Stall         (Pipe_Stall),
        .Eret               (Eret),
        .ReadData           (ReadData),
        .M_Stall_Controller (M_Stall_Controller),
        .AddrError          (AddrError),
        .BusError           (BusError),
        .DataMem_Addr       (DataMem_Addr),
        .DataMem_WriteData  (DataMem_WriteData),
        .DataMem_ByteEn     (DataMem_ByteEn),
        .DataMem_Read       (DataMem_Read),
        .DataMem_Write      (DataMem_Write),
        .DataMem_Ack        (DataMem_Ack),
        .DataMem_ReadData   (DataMem_ReadData)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Expected per-cycle outputs, driven by the transaction model.
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_rd, exp_wr, exp_aerr, exp_berr;
    logic [29:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rdata;

    // LL reservation model.
    logic        m_ll_v;
    logic [29:0] m_ll_a;

    // Bus monitor.
    int          txn_cnt = 0;
    int          stall_cnt = 0;
    int          berr_cnt = 0;
    logic [29:0] last_addr;
    logic [3:0]  last_be;
    logic [31:0] last_wd;

    // Compare DUT outputs against the model in mid-cycle, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            check("stall",     32'(M_Stall_Controller), 32'(exp_stall));
            check("rd_strobe", 32'(DataMem_Read),       32'(exp_rd));
            check("wr_strobe", 32'(DataMem_Write),      32'(exp_wr));
            check("addr_err",  32'(AddrError),          32'(exp_aerr));
            check("bus_err",   32'(BusError),           32'(exp_berr));
            check("rdata",     ReadData,                exp_rdata);
            if (exp_rd || exp_wr) begin
                check("bus_addr",   32'(DataMem_Addr),   32'(exp_addr));
                check("bus_byteen", 32'(DataMem_ByteEn), 32'(exp_be));
            end
            if (exp_wr) check("bus_wdata", DataMem_WriteData, exp_wd);
        end
        if (DataMem_Read || DataMem_Write) begin
            last_addr = DataMem_Addr;
            last_be   = DataMem_ByteEn;
            last_wd   = DataMem_WriteData;
            if (DataMem_Ack) txn_cnt++;
        end
        if (M_Stall_Controller) stall_cnt++;
        if (BusError) berr_cnt++;
    end

    task automatic go_idle();
        MemRead = 0; MemWrite = 0; LLSC = 0; Size = 2'b00; SignExtend = 0;
        Address = '0; WriteData = '0; Pipe_Stall = 0; Eret = 0; DataMem_Ack = 0;
        exp_stall = 0; exp_rd = 0; exp_wr = 0; exp_aerr = 0; exp_berr = 0;
    endtask

    // One MEM-stage instruction. ack_dly = strobe cycles before Ack (-1 = never),
    // hold = cycles Pipe_Stall stays high after the access completes.
    task automatic run_op(input logic rd, input logic wr, input logic llsc,
                          input logic [1:0] sz, input logic sx,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int ack_dly, input logic [31:0] bus_data, input int hold);
        int          nb, off;
        logic        aligned, bus, ll_hit, timed_out;
        logic [3:0]  be;
        logic [31:0] wrep, val, new_rdata;
        nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        off = int'(addr[1:0]);
        aligned = (off % nb) == 0;
        be = '0; wrep = '0; val = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nb) be[3-i] = 1'b1;
            wrep[31-8*i -: 8] = wd[8*(nb-1-(i % nb)) +: 8];
        end
        if (aligned) begin
            for (int j = 0; j < nb; j++) val = (val << 8) | 32'(bus_data[31-8*(off+j) -: 8]);
            if (sx && nb < 4 && val[8*nb-1]) val = val | ~((32'd1 << (8*nb)) - 32'd1);
        end
        ll_hit    = m_ll_v && (m_ll_a == addr[31:2]);
        bus       = aligned && !(wr && llsc && !ll_hit);
        timed_out = 0;

        // Request cycle.
        @(posedge clock); #1;
        MemRead = rd; MemWrite = wr; LLSC = llsc; Size = sz; SignExtend = sx;
        Address = addr; WriteData = wd; Pipe_Stall = 0;
        exp_aerr = !aligned; exp_stall = aligned;
        if (!aligned) begin
            @(posedge clock); #1;
            go_idle();
            return;
        end

        // Strobe cycles.
        if (bus) begin
            exp_addr = addr[31:2]; exp_be = be; exp_wd = wrep;
            for (int k = 0; k < 1000; k++) begin
                @(posedge clock); #1;
                exp_rd = !wr; exp_wr = wr;
                if (k == ack_dly) begin
                    DataMem_Ack = 1; DataMem_ReadData = bus_data;
                    break;
                end
                DataMem_ReadData = 32'h5A5A_5A5A;
                if (ack_dly < 0 && k == TO - 1) begin
                    timed_out = 1;
                    break;
                end
            end
        end

        if (timed_out)      new_rdata = 32'd0;
        else if (wr && llsc) new_rdata = bus ? 32'd1 : 32'd0;
        else if (!wr)       new_rdata = val;
        else                new_rdata = exp_rdata;

        // Completion cycles: stall released, result held while the pipe is stalled.
        for (int d = 0; d <= hold; d++) begin
            @(posedge clock); #1;
            DataMem_Ack = 0; Pipe_Stall = (d < hold);
            exp_rd = 0; exp_wr = 0; exp_stall = 0;
            exp_berr = timed_out && (d == 0);
            if (d == 0) exp_rdata = new_rdata;
        end

        if (bus && !timed_out) begin
            if (!wr && llsc) begin
                m_ll_v = 1; m_ll_a = addr[31:2];
            end else if (wr && m_ll_a == addr[31:2]) begin
                m_ll_v = 0;
            end
        end

        @(posedge clock); #1;
        go_idle();
    endtask

    task automatic eret_pulse();
        @(posedge clock); #1; Eret = 1;
        @(posedge clock); #1; Eret = 0;
        m_ll_v = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, s0, b0;
        go_idle();
        reset_n = 0; DataMem_ReadData = '0;
        m_ll_v = 0; m_ll_a = '0;
        exp_rdata = '0; exp_addr = '0; exp_be = '0; exp_wd = '0;
        last_addr = '0; last_be = '0; last_wd = '0;
        #12;
        check("rst_rdata",  ReadData, 32'd0);
        check("rst_read",   32'(DataMem_Read), 32'd0);
        check("rst_write",  32'(DataMem_Write), 32'd0);
        check("rst_byteen", 32'(DataMem_ByteEn), 32'd0);
        check("rst_addr",   32'(DataMem_Addr), 32'd0);
        check("rst_stall",  32'(M_Stall_Controller), 32'd0);
        check("rst_berr",   32'(BusError), 32'd0);
        reset_n = 1;
        chk_en  = 1;

        // Word load, Ack three cycles after the strobe rises.
        t0 = txn_cnt; s0 = stall_cnt;
        run_op(1, 0, 0, 2'b10, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0);
        check("wl_rdata",  ReadData, 32'hDEADBEEF);
        check("wl_addr",   32'(last_addr), 32'h40);
        check("wl_be",     32'(last_be), 32'hF);
        check("wl_stall",  32'(stall_cnt - s0), 32'd5);
        check("wl_txn",    32'(txn_cnt - t0), 32'd1);

        // Byte and half loads, signed and unsigned.
        run_op(1, 0, 0, 2'b00, 1, 32'h103, 32'h0, 0, 32'h123456F0, 0);
        check("lbs_rdata", ReadData, 32'hFFFFFFF0);
        check("lbs_be",    32'(last_be), 32'h1);
        run_op(1, 0, 0, 2'b00, 0, 32'h103, 32'h0, 1, 32'h123456F0, 0);
        check("lbu_rdata", ReadData, 32'h000000F0);
        run_op(1, 0, 0, 2'b01, 1, 32'h102, 32'h0, 0, 32'h12348001, 0);
        check("lhs_rdata", ReadData, 32'hFFFF8001);
        run_op(1, 0, 0, 2'b00, 0, 32'h101, 32'h0, 2, 32'h11AB2233, 0);
        check("lb1_rdata", ReadData, 32'h000000AB);
        check("lb1_be",    32'(last_be), 32'h4);

        // Stores: lane replication.
        t0 = txn_cnt;
        run_op(0, 1, 0, 2'b01, 0, 32'h202, 32'h0000ABCD, 2, 32'h0, 0);
        check("sh_be",    32'(last_be), 32'h3);
        check("sh_wdata", last_wd, 32'hABCDABCD);
        check("sh_txn",   32'(txn_cnt - t0), 32'd1);
        check("sh_rdata_held", ReadData, 32'h000000AB);
        run_op(0, 1, 0, 2'b00, 0, 32'h201, 32'h00000077, 0, 32'h0, 0);
        check("sb_wdata", last_wd, 32'h77777777);
        check("sb_be",    32'(last_be), 32'h4);

        // LL / SC sequences.
        run_op(1, 0, 1, 2'b10, 0, 32'h300, 32'h0, 0, 32'h0BADF00D, 0);
        check("ll_rdata", ReadData, 32'h0BADF00D);
        t0 = txn_cnt;
        run_op(0, 1, 1, 2'b10, 0, 32'h300, 32'h00001234, 1, 32'h0, 0);
        check("sc_ok_rdata", ReadData, 32'd1);
        check("sc_ok_txn",   32'(txn_cnt - t0), 32'd1);
        t0 = txn_cnt;
        run_op(0, 1, 1, 2'b10, 0, 32'h300, 32'h00005678, 0, 32'h0, 0);
        check("sc2_rdata", ReadData, 32'd0);
        check("sc2_txn",   32'(txn_cnt - t0), 32'd0);
        run_op(1, 0, 1, 2'b10, 0, 32'h300, 32'h0, 0, 32'h01010101, 0);
        eret_pulse();
        t0 = txn_cnt;
        run_op(0, 1, 1, 2'b10, 0, 32'h300, 32'h0000AAAA, 0, 32'h0, 0);
        check("sc_eret_rdata", ReadData, 32'd0);
        check("sc_eret_txn",   32'(txn_cnt - t0), 32'd0);
        run_op(1, 0, 1, 2'b10, 0, 32'h300, 32'h0, 0, 32'h02020202, 0);
        run_op(0, 1, 0, 2'b10, 0, 32'h300, 32'h0000BBBB, 0, 32'h0, 0);
        run_op(0, 1, 1, 2'b10, 0, 32'h300, 32'h0000CCCC, 0, 32'h0, 0);
        check("sc_after_st_rdata", ReadData, 32'd0);
        run_op(1, 0, 1, 2'b10, 0, 32'h300, 32'h0, 0, 32'h03030303, 0);
        t0 = txn_cnt;
        run_op(0, 1, 1, 2'b10, 0, 32'h304, 32'h0000DDDD, 0, 32'h0, 0);
        check("sc_other_rdata", ReadData, 32'd0);
        check("sc_other_txn",   32'(txn_cnt - t0), 32'd0);

        // Misaligned accesses: no bus traffic.
        t0 = txn_cnt; s0 = stall_cnt;
        run_op(1, 0, 0, 2'b10, 0, 32'h101, 32'h0, 0, 32'h0, 0);
        run_op(0, 1, 0, 2'b01, 0, 32'h203, 32'h1111, 0, 32'h0, 0);
        check("mis_txn",   32'(txn_cnt - t0), 32'd0);
        check("mis_stall", 32'(stall_cnt - s0), 32'd0);

        // Pipe_Stall held 4 cycles after Ack: exactly one bus transaction.
        t0 = txn_cnt;
        run_op(1, 0, 0, 2'b10, 0, 32'h104, 32'h0, 0, 32'hCAFEBABE, 4);
        check("hold_txn",   32'(txn_cnt - t0), 32'd1);
        check("hold_rdata", ReadData, 32'hCAFEBABE);

        // A stray Ack in IDLE is ignored.
        @(posedge clock); #1; DataMem_Ack = 1; DataMem_ReadData = 32'hFFFF0000;
        @(posedge clock); #1; DataMem_Ack = 0;
        check("idle_ack_rdata", ReadData, 32'hCAFEBABE);

`ifdef DMEM_TIMEOUT_EN
        // Without an Ack the access aborts after TO strobe cycles; the LL reservation survives.
        run_op(1, 0, 1, 2'b10, 0, 32'h300, 32'h0, 0, 32'h04040404, 0);
        t0 = txn_cnt; b0 = berr_cnt; s0 = stall_cnt;
        run_op(1, 0, 0, 2'b10, 0, 32'h500, 32'h0, -1, 32'h0, 0);
        check("to_rdata", ReadData, 32'd0);
        check("to_berr",  32'(berr_cnt - b0), 32'd1);
        check("to_stall", 32'(stall_cnt - s0), 32'(TO + 1));
        check("to_txn",   32'(txn_cnt - t0), 32'd0);
        run_op(0, 1, 1, 2'b10, 0, 32'h300, 32'h0000EEEE, 0, 32'h0, 0);
        check("to_sc_rdata", ReadData, 32'd1);
`else
        // Without the timeout the access waits for a late Ack.
        t0 = txn_cnt; b0 = berr_cnt; s0 = stall_cnt;
        run_op(1, 0, 0, 2'b10, 0, 32'h500, 32'h0, 20, 32'h600DF00D, 0);
        check("late_rdata", ReadData, 32'h600DF00D);
        check("late_stall", 32'(stall_cnt - s0), 32'd22);
        check("late_berr",  32'(berr_cnt - b0), 32'd0);
        check("late_txn",   32'(txn_cnt - t0), 32'd1);
`endif

        // Reset mid-ACCESS: strobes drop at once, the LL reservation is lost.
        run_op(1, 0, 1, 2'b10, 0, 32'h300, 32'h0, 0, 32'h05050505, 0);
        chk_en = 0;
        @(posedge clock); #1;
        MemRead = 1; Size = 2'b10; Address = 32'h400;
        @(posedge clock); #1;
        check("rstm_pre_read", 32'(DataMem_Read), 32'd1);
        #2 reset_n = 0;
        #1;
        check("rstm_read",   32'(DataMem_Read), 32'd0);
        check("rstm_byteen", 32'(DataMem_ByteEn), 32'd0);
        check("rstm_addr",   32'(DataMem_Addr), 32'd0);
        check("rstm_rdata",  ReadData, 32'd0);
        go_idle();
        #1;
        check("rstm_stall",  32'(M_Stall_Controller), 32'd0);
        @(posedge clock); #1;
        reset_n = 1;
        m_ll_v = 0; exp_rdata = '0;
        chk_en = 1;
        t0 = txn_cnt;
        run_op(0, 1, 1, 2'b10, 0, 32'h300, 32'h0000FFFF, 0, 32'h0, 0);
        check("rstm_sc_txn", 32'(txn_cnt - t0), 32'd0);
        run_op(1, 0, 0, 2'b10, 0, 32'h104, 32'h0, 1, 32'h01020304, 0);
        check("rstm_load", ReadData, 32'h01020304);

        @(posedge clock); #1;
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_controller.md
Name: data_mem_controller

Overview:
MEM-stage data memory controller. Translates the MEM-stage load/store (incl. LL/SC) into a req/ack data-bus transaction with big-endian byte lanes. Drives M_Stall_Controller into the hazard controller until the access completes. Returns aligned, extended read data (or the SC status word) to the MEM/WB path.

Parameters:
TIMEOUT_CYCLES, 64, bus cycles without ack before abort (only with DMEM_TIMEOUT_EN)

Ports:
clock  in  1  core clock
reset_n  in  1  async active-low reset
MemRead  in  1  MEM stage is a load
MemWrite  in  1  MEM stage is a store
LLSC  in  1  qualifies load as LL, store as SC
Size  in  2  00 byte, 01 half, 10 word
SignExtend  in  1  sign-extend byte/half loads
Address  in  32  byte address
WriteData  in  32  store data, right-justified
Pipe_Stall  in  1  IF_Stall from hazard controller; MEM instruction held
Eret  in  1  clears LL bit
ReadData  out  32  load data, or SC status (1/0)
M_Stall_Controller  out  1  stall request to hazard controller
AddrError  out  1  misaligned access, no bus traffic
BusError  out  1  timeout abort (DMEM_TIMEOUT_EN only, else tied 0)
DataMem_Addr  out  30  word address
DataMem_WriteData  out  32  lane-replicated store data
DataMem_ByteEn  out  4  bit3 = bits 31:24 = byte offset 0
DataMem_Read  out  1  read strobe
DataMem_Write  out  1  write strobe
DataMem_Ack  in  1  one-cycle completion
DataMem_ReadData  in  32  valid with ack

Behaviour:
- Reset (async, asserting reset_n=0): state IDLE, all strobes/ByteEn/Addr 0, ReadData 0, LL bit 0, errors 0. Reset mid-transaction drops strobes immediately; the pending transaction is abandoned.
- Access valid: Req = (MemRead|MemWrite) & aligned. Misaligned: half with Address[0]=1; word with Address[1:0]!=0. Misaligned -> AddrError=1 combinationally; no stall; no bus activity.
- FSM IDLE:
  - Req -> ACCESS. M_Stall_Controller=1 combinationally this cycle.
  - SC with LL bit=0 or Address[31:2]!=LL address -> DONE directly with ReadData=0 and no bus write; stall still high this cycle.
- FSM ACCESS:
  - Strobes, Addr, ByteEn and WriteData are registered and held stable until Ack. Stall stays 1.
  - On Ack:
    - Loads: capture extracted data.
    - Successful SC: ReadData=1 and clear LL bit.
    - LL load: set LL bit and latch Address[31:2].
    - Strobes drop the next cycle, state -> DONE.
- FSM DONE:
  - M_Stall_Controller=0 and ReadData is held.
  - Pipe_Stall=1 -> remain in DONE; never re-issue.
  - Pipe_Stall=0 -> IDLE; the instruction leaves MEM at this edge.
- Minimum latency with Ack in the first strobe cycle: stall for 2 cycles, instruction advances on the 3rd.
- Byte lanes (big-endian):
  - Byte ByteEn = 4'b1000 >> Address[1:0].
  - Half: offset 0 -> 1100, offset 2 -> 0011.
  - Word -> 1111.
  - Store data replicated: byte x4, half x2.
- Read extraction: select the lane matching ByteEn, then zero- or sign-extend per SignExtend.
- Ack in IDLE/DONE is ignored.
- Eret clears the LL bit. If Eret coincides with an LL ack, Eret wins.
- Any successful store (SC or plain) to the LL word clears the LL bit.

Optional Feature:
DMEM_TIMEOUT_EN:
- Defined: an 8-bit-or-wider counter runs in ACCESS. On reaching TIMEOUT_CYCLES without Ack:
  - drop strobes, pulse BusError 1 cycle, ReadData=0, go DONE;
  - LL state unchanged.
- Undefined: no counter; ACCESS waits indefinitely; BusError tied 0.

Test Plan:
- Word load: Address=0x100, bus Ack 3 cycles after strobe with data 0xDEADBEEF -> DataMem_Addr=0x40, ByteEn=1111, stall high 5 cycles, ReadData=0xDEADBEEF.
- Signed byte load: Address=0x103, SignExtend=1, bus data 0x123456F0 -> ByteEn=0001, ReadData=0xFFFFFFF0; with SignExtend=0 -> 0x000000F0.
- Half store: Address=0x202, WriteData=0x0000ABCD -> ByteEn=0011, DataMem_WriteData=0xABCDABCD, single write strobe burst, AddrError=0.
- LL 0x300 then SC 0x300 -> SC bus write issued, ReadData=1. Second SC -> no bus write, ReadData=0. LL, Eret, SC -> ReadData=0.
- Misaligned word at 0x101 -> AddrError=1, M_Stall_Controller=0, no strobe. Pipe_Stall held 4 cycles after Ack -> exactly one bus transaction, ReadData stable.
- Reset_n pulsed low mid-ACCESS -> strobes 0 immediately, state IDLE. With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, no Ack -> BusError pulse after 8 cycles, stall released.
